// File: rtl/mover_pkg.sv
// ---------------------------------------------------------------------------
// mover_pkg
// Shared definitions for the single-bit mover link receiver.
//   rx_state_t      : receiver FSM state encoding
//   LINE_IDLE       : level of an idle serial line
//   parity_mismatch : even-parity check helper (data zero-extended to 32 bits)
// ---------------------------------------------------------------------------
package mover_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        PARITY  = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Returns 1 when data plus parity bit do not have even parity.
    function automatic logic parity_mismatch(input logic [31:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_word_receiver_if
// Word-side bundle of the serial receiver.
//   y_data/y_valid/y_ready : one-entry valid/ready word output
//   frame_err/overrun/parity_err : single-cycle status pulses
// Modports: master = receiver (word producer), slave = consumer.
// ---------------------------------------------------------------------------
interface serial_word_receiver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    modport master (
        output y_data, y_valid, frame_err, overrun, parity_err,
        input  y_ready
    );

    modport slave (
        input  y_data, y_valid, frame_err, overrun, parity_err,
        output y_ready
    );
endinterface

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for one asynchronous input bit.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset; all flops load RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronised output (STAGES clocks of latency)
// Parameters: STAGES (>=2), RST_VAL.
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift chain; reset to RST_VAL so an idle line is not seen as a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
// Receiving end of the single-bit mover link: synchronises the line, detects
// a start bit, assembles WIDTH data bits LSB-first, checks the stop bit and
// offers the word on a one-entry valid/ready holding register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   a     : serial line, idle high
//   y     : word output bundle (serial_word_receiver_if.master)
// Parameters: WIDTH (1..32), SYNC_STG (>=2).
// Build option: define PARITY_EN to expect one even-parity bit between the
// data and the stop bit; parity_err is then a status pulse (word still
// delivered). Without PARITY_EN parity_err is constant 0.
// ---------------------------------------------------------------------------
module serial_word_receiver
    import mover_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SYNC_STG = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a,
    serial_word_receiver_if.master y
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             w_as;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_parity_err;
    logic             w_last_bit;
    logic             w_good;
    logic             w_bad;
`ifdef PARITY_EN
    logic             r_par_bit;
`endif

    bit_sync #(
        .STAGES  (SYNC_STG),
        .RST_VAL (LINE_IDLE)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (a),
        .o_q     (w_as)
    );

    // Next-state logic and good/bad stop-bit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_last_bit  = (r_bit_cnt == CW'(WIDTH - 1));
        case (r_state)
            IDLE: begin
                if (w_as == 1'b0) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (w_last_bit) begin
`ifdef PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
            end
            STOP: begin
                if (w_as == 1'b1) begin
                    w_state_nxt = IDLE;
                    w_good      = 1'b1;
                end else begin
                    w_state_nxt = WAIT_HI;
                    w_bad       = 1'b1;
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must not look like a new start bit.
                if (w_as == 1'b1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_HI;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter, shift register and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
`ifdef PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == DATA) begin
                r_shreg[r_bit_cnt] <= w_as;
                // Saturate at the last bit so the counter never wraps.
                if (!w_last_bit) begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
`ifdef PARITY_EN
            if (r_state == PARITY) begin
                r_par_bit <= w_as;
            end
`endif
        end
    end

    // Holding register and status pulses; a good frame loads on the stop-bit edge
    // only if the register is empty or being emptied in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= 1'b0;
`ifdef PARITY_EN
            r_parity_err <= w_good & parity_mismatch(32'(r_shreg), r_par_bit);
`else
            r_parity_err <= 1'b0;
`endif
            if (w_good) begin
                if (!r_valid || y.y_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && y.y_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign y.y_data     = r_data;
    assign y.y_valid    = r_valid;
    assign y.frame_err  = r_frame_err;
    assign y.overrun    = r_overrun;
    assign y.parity_err = r_parity_err;

endmodule

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_word_receiver
// Self-checking bench for serial_word_receiver (WIDTH=8, SYNC_STG=2).
// Honours PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_serial_word_receiver;

    localparam int WIDTH    = 8;
    localparam int SYNC_STG = 2;
`ifdef PARITY_EN
    localparam bit PE_ON = 1'b1;
`else
    localparam bit PE_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic a;

    serial_word_receiver_if #(.WIDTH(WIDTH)) yif ();

    serial_word_receiver #(
        .WIDTH    (WIDTH),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .y     (yif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed behaviour, collected away from the active edge.
    logic [7:0] got_q[$];
    int         cnt_fe = 0;
    int         cnt_ov = 0;
    int         cnt_pe = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (yif.y_valid && yif.y_ready) got_q.push_back(yif.y_data);
            if (yif.frame_err)  cnt_fe++;
            if (yif.overrun)    cnt_ov++;
            if (yif.parity_err) cnt_pe++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one line bit for one clock.
    task automatic send_bit(input logic b);
        a = b;
        tick();
    endtask

    task automatic idle(input int n);
        a = 1'b1;
        repeat (n) tick();
    endtask

    // Full frame; par_flip inverts the (even) parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) send_bit(d[i]);
`ifdef PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) begin end
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_flip;
        logic       exp_word;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base_n, base_fe, base_ov, base_pe;
        logic [7:0] exp_q[$];
        int exp_fe, exp_pe;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, PE_ON};

        a           = 1'b1;
        yif.y_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) tick();
        check("reset_y_valid", {31'd0, yif.y_valid}, 32'd0);
        check("reset_y_data", {24'd0, yif.y_data}, 32'd0);
        check("reset_pulses", {29'd0, yif.frame_err, yif.overrun, yif.parity_err}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Table-driven single frames, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            base_n  = got_q.size();
            base_fe = cnt_fe;
            base_pe = cnt_pe;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_flip);
            idle(6);
            check($sformatf("vec%0d_words", v), got_q.size() - base_n, {31'd0, vecs[v].exp_word});
            if (vecs[v].exp_word && got_q.size() > base_n)
                check($sformatf("vec%0d_data", v), {24'd0, got_q[got_q.size()-1]}, {24'd0, vecs[v].data});
            check($sformatf("vec%0d_frame_err", v), cnt_fe - base_fe, {31'd0, vecs[v].exp_fe});
            check($sformatf("vec%0d_parity_err", v), cnt_pe - base_pe, {31'd0, vecs[v].exp_pe});
        end

        // 1: latency of SYNC_STG+1 edges from the stop bit, single-cycle valid.
        send_frame(8'h5A, 1'b1, 1'b0);
        tick();
        check("t1_valid_early", {31'd0, yif.y_valid}, 32'd0);
        tick();
        check("t1_valid_on_time", {31'd0, yif.y_valid}, 32'd1);
        check("t1_data", {24'd0, yif.y_data}, 32'h5A);
        tick();
        check("t1_valid_one_cycle", {31'd0, yif.y_valid}, 32'd0);
        idle(3);

        // 2: holding register full -> second word dropped, overrun once.
        yif.y_ready = 1'b0;
        base_n  = got_q.size();
        base_ov = cnt_ov;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        check("t2_valid_held", {31'd0, yif.y_valid}, 32'd1);
        check("t2_data_kept", {24'd0, yif.y_data}, 32'h11);
        check("t2_overrun_once", cnt_ov - base_ov, 32'd1);
        yif.y_ready = 1'b1;
        tick();
        check("t2_drained", {31'd0, yif.y_valid}, 32'd0);
        check("t2_words", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("t2_word", {24'd0, got_q[base_n]}, 32'h11);
        idle(3);

        // 3: bad stop bit followed by a 20-cycle break.
        base_n  = got_q.size();
        base_fe = cnt_fe;
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (20) send_bit(1'b0);
        check("t3_frame_err_once", cnt_fe - base_fe, 32'd1);
        check("t3_no_word", got_q.size() - base_n, 32'd0);
        idle(4);
        check("t3_no_restart", cnt_fe - base_fe, 32'd1);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(5);
        check("t3_recovered", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("t3_word", {24'd0, got_q[base_n]}, 32'h03);

        // 4: back-to-back frames with zero gap.
        base_n = got_q.size();
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        idle(6);
        check("t4_words", got_q.size() - base_n, 32'd2);
        if (got_q.size() >= base_n + 2) begin
            check("t4_first", {24'd0, got_q[base_n]}, 32'h01);
            check("t4_second", {24'd0, got_q[base_n+1]}, 32'h80);
        end

        // 5: reset in the middle of a frame while a word is held.
        yif.y_ready = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0);
        idle(4);
        check("t5_held_before", {31'd0, yif.y_valid}, 32'd1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ ((8'h3C >> i) & 8'h01) != 8'h00);
        a = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reset_valid", {31'd0, yif.y_valid}, 32'd0);
        check("t5_reset_data", {24'd0, yif.y_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        yif.y_ready = 1'b1;
        base_n  = got_q.size();
        base_fe = cnt_fe;
        idle(4);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(6);
        check("t5_words", got_q.size() - base_n, 32'd1);
        if (got_q.size() > base_n) check("t5_word", {24'd0, got_q[base_n]}, 32'hA5);
        check("t5_no_frame_err", cnt_fe - base_fe, 32'd0);

`ifdef PARITY_EN
        // 6: even-parity status on 0x07.
        base_n  = got_q.size();
        base_pe = cnt_pe;
        send_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) send_bit(i < 3);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(5);
        check("t6_parity_err", cnt_pe - base_pe, 32'd1);
        if (got_q.size() > base_n) check("t6_word", {24'd0, got_q[base_n]}, 32'h07);
        base_pe = cnt_pe;
        send_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) send_bit(i < 3);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(5);
        check("t6_parity_ok", cnt_pe - base_pe, 32'd0);
        check("t6_words", got_q.size() - base_n, 32'd2);
`endif

        // Randomised frames against a queue-based reference model.
        base_n  = got_q.size();
        base_fe = cnt_fe;
        base_pe = cnt_pe;
        exp_fe  = 0;
        exp_pe  = 0;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            logic       good;
            logic       flip;
            int         gap;
            d    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            flip = ($urandom_range(0, 4) == 0);
            gap  = good ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            send_frame(d, good, flip);
            if (good) begin
                exp_q.push_back(d);
                if (PE_ON && flip) exp_pe++;
            end else begin
                exp_fe++;
            end
            if (gap > 0) idle(gap);
        end
        idle(8);
        check("rand_words", got_q.size() - base_n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_n + i < got_q.size())
                check($sformatf("rand_word%0d", i), {24'd0, got_q[base_n+i]}, {24'd0, exp_q[i]});
        end
        check("rand_frame_err", cnt_fe - base_fe, exp_fe);
        check("rand_parity_err", cnt_pe - base_pe, exp_pe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
